// File: rtl/game_pkg.sv
// Shared game types: grid bounds, tile coordinate type and the move
// direction used by the hero arbiter.
package game_pkg;

  localparam logic [3:0] GRID_MAX = 4'd15;

  typedef logic [3:0] coord_t;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_LEFT,
    DIR_RIGHT,
    DIR_UP,
    DIR_DOWN
  } dir_e;

  // Button-vector bit for a direction; bit order is {down, up, right, left}.
  function automatic logic [3:0] dir_onehot(dir_e d);
    case (d)
      DIR_LEFT:  return 4'b0001;
      DIR_RIGHT: return 4'b0010;
      DIR_UP:    return 4'b0100;
      DIR_DOWN:  return 4'b1000;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for one raw button plus a rising-edge press pulse.
// A button that is still held when reset is released must be let go before
// it can produce a press or a held level again, so a held button never
// looks like a fresh press after reset.
module btn_sync_edge (
  input  logic clk_1,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  logic s1;
  logic s2;
  logic s3;
  logic settled;
  logic armed;

  // Synchroniser chain, history flop and release-after-reset tracking.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      settled <= 1'b0;
      armed   <= 1'b0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      s3      <= s2;
      settled <= 1'b1;
      // s1 only carries a real post-reset sample once settled is set.
      if (settled && !s1) begin
        armed <= 1'b1;
      end
    end
  end

  assign level = s2 & armed;
  assign press = s2 & ~s3 & armed;

endmodule

// File: rtl/hero_move_ctrl.sv
// Hero tile-position controller: four synchronised buttons, one step per
// press, optional auto-repeat while the winning button is held, fixed
// priority left > right > up > down, clamped at the 16x16 grid edges.
module hero_move_ctrl
  import game_pkg::*;
#(
  parameter int START_X       = 0,
  parameter int START_Y       = 0,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic       clk_1,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  output logic [3:0] position_hero_x,
  output logic [3:0] position_hero_y
);

  logic [3:0] btn;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] evt;
  logic [3:0] cur_oh;
  logic       cur_held;
  logic       rep_evt;
  dir_e       win;
  dir_e       cur_reg;
  dir_e       cur_next;
  coord_t     x_reg;
  coord_t     x_next;
  coord_t     y_reg;
  coord_t     y_next;

  assign btn = {down, up, right, left};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      btn_sync_edge u_sync (
        .clk_1 (clk_1),
        .rst   (rst),
        .btn   (btn[gi]),
        .level (level[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  // The direction that last stepped stays "current" while its button is held.
  assign cur_oh   = dir_onehot(cur_reg);
  assign cur_held = |(level & cur_oh);

  generate
    if (REPEAT_CYCLES > 0) begin : g_repeat
      localparam int CW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
      localparam logic [CW-1:0] RMAX = CW'(REPEAT_CYCLES - 1);

      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;

      // Counter value RMAX means REPEAT_CYCLES held cycles since the last step.
      assign rep_evt = cur_held && (cnt_reg == RMAX);

      // Hold counter restarts on any step, release or change of winner.
      always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (win != DIR_NONE || !cur_held) begin
          cnt_next = '0;
        end
      end

      // Hold counter register.
      always_ff @(posedge clk_1) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end else begin : g_no_repeat
      assign rep_evt = 1'b0;
    end
  endgenerate

  // Fixed-priority arbitration; losing events are simply dropped.
  always_comb begin
    evt = press | (rep_evt ? cur_oh : 4'b0000);
    win = DIR_NONE;
    if (evt[0]) begin
      win = DIR_LEFT;
    end else if (evt[1]) begin
      win = DIR_RIGHT;
    end else if (evt[2]) begin
      win = DIR_UP;
    end else if (evt[3]) begin
      win = DIR_DOWN;
    end
  end

  // Next position with edge clamping, and next current direction.
  always_comb begin
    x_next   = x_reg;
    y_next   = y_reg;
    cur_next = cur_reg;
    case (win)
      DIR_LEFT:  x_next = (x_reg == 4'd0)    ? x_reg : x_reg - 4'd1;
      DIR_RIGHT: x_next = (x_reg == GRID_MAX) ? x_reg : x_reg + 4'd1;
      DIR_UP:    y_next = (y_reg == 4'd0)    ? y_reg : y_reg - 4'd1;
      DIR_DOWN:  y_next = (y_reg == GRID_MAX) ? y_reg : y_reg + 4'd1;
      default:   ;
    endcase
    if (win != DIR_NONE) begin
      cur_next = win;
    end else if (!cur_held) begin
      cur_next = DIR_NONE;
    end
  end

  // Position and current-direction registers.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      x_reg   <= coord_t'(START_X);
      y_reg   <= coord_t'(START_Y);
      cur_reg <= DIR_NONE;
    end else begin
      x_reg   <= x_next;
      y_reg   <= y_next;
      cur_reg <= cur_next;
    end
  end

  assign position_hero_x = x_reg;
  assign position_hero_y = y_reg;

endmodule

// File: tb/tb_hero_move_ctrl.sv
// Testbench for hero_move_ctrl: three instances (no repeat, repeat 4,
// repeat 2 with start (5,5)) share the buttons and are compared every cycle
// against a sample-history reference model, plus directed constant checks.
module tb_hero_move_ctrl;

  localparam int NI   = 3;
  localparam int MAXE = 4096;
  localparam int NOZ  = MAXE + 10;

  logic       clk_1 = 1'b0;
  logic       rst   = 1'b1;
  logic       left  = 1'b0;
  logic       right = 1'b0;
  logic       up    = 1'b0;
  logic       down  = 1'b0;
  logic [3:0] px [NI];
  logic [3:0] py [NI];

  always #5 clk_1 = ~clk_1;

  hero_move_ctrl #(.START_X(0), .START_Y(0), .REPEAT_CYCLES(0)) u_r0 (
    .clk_1(clk_1), .rst(rst), .left(left), .right(right), .up(up), .down(down),
    .position_hero_x(px[0]), .position_hero_y(py[0]));

  hero_move_ctrl #(.START_X(0), .START_Y(0), .REPEAT_CYCLES(4)) u_r4 (
    .clk_1(clk_1), .rst(rst), .left(left), .right(right), .up(up), .down(down),
    .position_hero_x(px[1]), .position_hero_y(py[1]));

  hero_move_ctrl #(.START_X(5), .START_Y(5), .REPEAT_CYCLES(2)) u_s (
    .clk_1(clk_1), .rst(rst), .left(left), .right(right), .up(up), .down(down),
    .position_hero_x(px[2]), .position_hero_y(py[2]));

  localparam logic [3:0] B_L = 4'b0001;
  localparam logic [3:0] B_R = 4'b0010;
  localparam logic [3:0] B_U = 4'b0100;
  localparam logic [3:0] B_D = 4'b1000;

  int rep_c [NI] = '{0, 4, 2};
  int st_x  [NI] = '{0, 0, 5};
  int st_y  [NI] = '{0, 0, 5};

  // Reference model state: position, last stepping button and its edge.
  int m_x    [NI];
  int m_y    [NI];
  int m_cur  [NI];
  int m_last [NI];

  // Raw button values sampled at each edge, the last reset edge, and the
  // first post-reset sample at which each button was seen released.
  logic [3:0] raw [0:MAXE-1];
  int first_zero [4];
  int n      = 0;
  int r_last = 0;
  int checks = 0;
  int errors = 0;

  // Synchronised level seen by the logic at edge e: the sample from two
  // edges earlier, provided it is after reset and the button had been
  // released since reset by then.
  function automatic logic lvl(int e, int b);
    int j;
    j = e - 2;
    if (j <= r_last) return 1'b0;
    if (first_zero[b] > j) return 1'b0;
    return raw[j][b];
  endfunction

  function automatic logic prs(int e, int b);
    logic older;
    older = (e - 3 > r_last) ? raw[e-3][b] : 1'b0;
    return lvl(e, b) && !older;
  endfunction

  task automatic model_edge();
    logic [3:0] ev;
    logic       held;
    int         win;
    if (rst) begin
      r_last = n;
      for (int b = 0; b < 4; b++) first_zero[b] = NOZ;
      for (int i = 0; i < NI; i++) begin
        m_x[i] = st_x[i]; m_y[i] = st_y[i]; m_cur[i] = -1; m_last[i] = n;
      end
      return;
    end
    for (int b = 0; b < 4; b++)
      if (first_zero[b] == NOZ && raw[n][b] == 1'b0) first_zero[b] = n;
    for (int i = 0; i < NI; i++) begin
      ev = 4'b0000;
      for (int b = 0; b < 4; b++) ev[b] = prs(n, b);
      if (rep_c[i] > 0 && m_cur[i] >= 0 && (n - m_last[i]) == rep_c[i]) begin
        held = 1'b1;
        for (int k = m_last[i] + 1; k <= n; k++)
          if (!lvl(k, m_cur[i])) held = 1'b0;
        if (held) ev[m_cur[i]] = 1'b1;
      end
      win = -1;
      for (int b = 3; b >= 0; b--) if (ev[b]) win = b;
      case (win)
        0: if (m_x[i] > 0)  m_x[i] = m_x[i] - 1;
        1: if (m_x[i] < 15) m_x[i] = m_x[i] + 1;
        2: if (m_y[i] > 0)  m_y[i] = m_y[i] - 1;
        3: if (m_y[i] < 15) m_y[i] = m_y[i] + 1;
        default: ;
      endcase
      if (win >= 0) begin
        m_cur[i]  = win;
        m_last[i] = n;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] act, input int exp);
    logic [3:0] e4;
    e4 = exp[3:0];
    checks++;
    assert (act === e4)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, e4, n);
    end
  endtask

  // One clock cycle: drive buttons/reset, advance the model, compare all.
  task automatic cyc(input logic [3:0] b, input logic r);
    {down, up, right, left} = b;
    rst = r;
    @(posedge clk_1);
    n++;
    raw[n] = b;
    model_edge();
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("x_inst%0d", i), px[i], m_x[i]);
      chk($sformatf("y_inst%0d", i), py[i], m_y[i]);
    end
  endtask

  task automatic press(input logic [3:0] b);
    cyc(b, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    $display("press %b -> r0 (%0d,%0d) r4 (%0d,%0d) s (%0d,%0d)",
             b, px[0], py[0], px[1], py[1], px[2], py[2]);
  endtask

  initial begin
    logic [3:0] rb;
    for (int b = 0; b < 4; b++) first_zero[b] = NOZ;
    for (int i = 0; i < NI; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_cur[i] = -1; m_last[i] = 0;
    end

    // Reset for two edges, then idle.
    @(negedge clk_1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("rst_x_r0", px[0], 0);
    chk("rst_y_r0", py[0], 0);
    chk("rst_x_s", px[2], 5);
    chk("rst_y_s", py[2], 5);
    for (int k = 0; k < 10; k++) cyc(4'b0000, 1'b0);
    chk("idle_x_r0", px[0], 0);

    // Press latency: change appears at the third edge.
    cyc(B_R, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("lat_edge2", px[0], 0);
    cyc(4'b0000, 1'b0);
    chk("lat_edge3", px[0], 1);
    press(B_R);
    press(B_R);
    chk("three_right_x", px[0], 3);
    chk("three_right_y", py[0], 0);

    // Back to the corner, then clamp checks.
    for (int k = 0; k < 3; k++) press(B_L);
    press(B_U);
    press(B_L);
    chk("clamp_ul_x", px[0], 0);
    chk("clamp_ul_y", py[0], 0);
    for (int k = 0; k < 16; k++) press(B_D);
    chk("down16_y", py[0], 15);
    press(B_D);
    chk("down17_y", py[0], 15);
    for (int k = 0; k < 16; k++) press(B_U);
    chk("up16_y", py[0], 0);

    // Auto-repeat: hold right for 13 cycles.
    for (int k = 0; k < 13; k++) cyc(B_R, 1'b0);
    for (int k = 0; k < 6; k++) cyc(4'b0000, 1'b0);
    chk("hold_r4_x", px[1], 4);
    chk("hold_r0_x", px[0], 1);
    $display("hold right 13 -> r0 x=%0d r4 x=%0d s x=%0d", px[0], px[1], px[2]);

    // Simultaneous presses from (5,5).
    cyc(4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) cyc(4'b0000, 1'b0);
    press(B_L | B_U);
    chk("lu_x_s", px[2], 4);
    chk("lu_y_s", py[2], 5);
    press(B_R | B_D);
    chk("rd_x_s", px[2], 5);
    chk("rd_y_s", py[2], 5);

    // Reset while down is held.
    cyc(4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) cyc(4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) press(B_R);
    for (int k = 0; k < 7; k++) press(B_D);
    chk("pre_x_r0", px[0], 3);
    chk("pre_y_r0", py[0], 7);
    for (int k = 0; k < 4; k++) cyc(B_D, 1'b0);
    cyc(B_D, 1'b1);
    for (int k = 0; k < 8; k++) cyc(B_D, 1'b0);
    chk("held_rst_x", px[0], 0);
    chk("held_rst_y", py[0], 0);
    for (int k = 0; k < 3; k++) cyc(4'b0000, 1'b0);
    press(B_D);
    chk("repress_y", py[0], 1);

    // Randomised phase: buttons toggle occasionally, rare resets.
    rb = 4'b0000;
    for (int k = 0; k < 1500; k++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) == 0) rb[b] = ~rb[b];
      cyc(rb, ($urandom_range(199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
